// File: rtl/huffman_job_arbiter_if.sv
// Requester, encoder-core and response signals of huffman_job_arbiter.
// slave = arbiter side, master = requesters/core/consumer side.
interface huffman_job_arbiter_if #(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned IP_WIDTH = 8,
  parameter int unsigned MAX_BITS = 40
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ*IP_WIDTH*3-1:0] req_weight;
  logic [NREQ-1:0]            req_mode;
  logic                       core_in_valid;
  logic [2:0]                 core_in_weight;
  logic                       core_out_mode;
  logic                       core_out_valid;
  logic                       core_out_code;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [IDW-1:0]             rsp_id;
  logic [MAX_BITS-1:0]        rsp_code;
  logic [5:0]                 rsp_len;
  logic                       rsp_ovf;
  logic                       rsp_err;
  logic                       busy;

  modport slave (
    input  req_valid, req_weight, req_mode, core_out_valid, core_out_code, rsp_ready,
    output req_ready, core_in_valid, core_in_weight, core_out_mode,
           rsp_valid, rsp_id, rsp_code, rsp_len, rsp_ovf, rsp_err, busy
  );

  modport master (
    output req_valid, req_weight, req_mode, core_out_valid, core_out_code, rsp_ready,
    input  req_ready, core_in_valid, core_in_weight, core_out_mode,
           rsp_valid, rsp_id, rsp_code, rsp_len, rsp_ovf, rsp_err, busy
  );
endinterface

// File: rtl/huffman_job_arbiter.sv
// Round-robin sharing of one Huffman encoder core among NREQ requesters, one job in flight.
// Define HJA_TIMEOUT_EN to abort a job whose core stays silent for TIMEOUT cycles in WAIT.
module huffman_job_arbiter #(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned IP_WIDTH = 8,
  parameter int unsigned MAX_BITS = 40,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  huffman_job_arbiter_if.slave bus
);
  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned FW  = IP_WIDTH * 3;
  localparam int unsigned CW  = $clog2(IP_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_FEED, S_WAIT, S_COLLECT, S_RESP, S_GAP
  } state_t;

  state_t              state;
  logic [IDW-1:0]      rr_ptr;
  logic [IDW-1:0]      gnt;
  logic [IDW-1:0]      pick;
  logic [IDW-1:0]      idx;
  logic                found;
  logic [FW-1:0]       frames [NREQ];
  logic [FW-1:0]       frame;
  logic [CW-1:0]       beat_cnt;
  logic [1:0]          gap_cnt;
  logic [NREQ-1:0]     req_ready_q;
  logic                civ_q;
  logic [2:0]          ciw_q;
  logic                mode_q;
  logic                rsp_valid_q;
  logic [MAX_BITS-1:0] code_q;
  logic [5:0]          len_q;
  logic                ovf_q;
  logic                busy_q;
`ifdef HJA_TIMEOUT_EN
  logic [7:0]          timer;
  logic                err_q;
`endif

  for (genvar i = 0; i < NREQ; i++) begin : g_frame
    assign frames[i] = bus.req_weight[i*FW +: FW];
  end

  // Scan downward so the requester nearest after rr_ptr is the last (winning) assignment.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    idx   = '0;
    for (int unsigned off = NREQ; off >= 1; off--) begin
      idx = IDW'((32'(rr_ptr) + off) % NREQ);
      if (bus.req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rr_ptr      <= IDW'(NREQ - 1);
      gnt         <= '0;
      frame       <= '0;
      beat_cnt    <= '0;
      gap_cnt     <= '0;
      req_ready_q <= '0;
      civ_q       <= 1'b0;
      ciw_q       <= '0;
      mode_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      code_q      <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
`ifdef HJA_TIMEOUT_EN
      timer       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      req_ready_q <= '0;
      case (state)
        S_IDLE: begin
          if (found) begin
            state             <= S_GRANT;
            busy_q            <= 1'b1;
            req_ready_q[pick] <= 1'b1;
            gnt               <= pick;
            rr_ptr            <= pick;
            code_q            <= '0;
            len_q             <= '0;
            ovf_q             <= 1'b0;
`ifdef HJA_TIMEOUT_EN
            err_q             <= 1'b0;
`endif
          end
        end
        S_GRANT: begin
          // Beat 0 goes out straight away; the latched copy is pre-shifted for beat 1.
          state    <= S_FEED;
          civ_q    <= 1'b1;
          ciw_q    <= frames[gnt][2:0];
          frame    <= frames[gnt] >> 3;
          mode_q   <= bus.req_mode[gnt];
          beat_cnt <= CW'(1);
        end
        S_FEED: begin
          if (beat_cnt == CW'(IP_WIDTH)) begin
            state <= S_WAIT;
            civ_q <= 1'b0;
            ciw_q <= '0;
`ifdef HJA_TIMEOUT_EN
            timer <= '0;
`endif
          end else begin
            ciw_q    <= frame[2:0];
            frame    <= frame >> 3;
            beat_cnt <= beat_cnt + CW'(1);
          end
        end
        S_WAIT: begin
          if (bus.core_out_valid) begin
            state  <= S_COLLECT;
            code_q <= {code_q[MAX_BITS-2:0], bus.core_out_code};
            len_q  <= 6'd1;
          end
`ifdef HJA_TIMEOUT_EN
          else if (timer == 8'(TIMEOUT - 1)) begin
            state       <= S_RESP;
            rsp_valid_q <= 1'b1;
            err_q       <= 1'b1;
            len_q       <= '0;
            mode_q      <= 1'b0;
          end else begin
            timer <= timer + 8'd1;
          end
`endif
        end
        S_COLLECT: begin
          if (bus.core_out_valid) begin
            if (len_q == 6'(MAX_BITS)) begin
              ovf_q <= 1'b1;
            end else begin
              code_q <= {code_q[MAX_BITS-2:0], bus.core_out_code};
              len_q  <= len_q + 6'd1;
            end
          end else begin
            state       <= S_RESP;
            rsp_valid_q <= 1'b1;
            mode_q      <= 1'b0;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            state       <= S_GAP;
            rsp_valid_q <= 1'b0;
`ifdef HJA_TIMEOUT_EN
            gap_cnt     <= err_q ? 2'd3 : 2'd1;
`else
            gap_cnt     <= 2'd1;
`endif
          end
        end
        S_GAP: begin
          if (gap_cnt == 2'd0) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 2'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.core_in_valid  = civ_q;
  assign bus.core_in_weight = ciw_q;
  assign bus.core_out_mode  = mode_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_id         = gnt;
  assign bus.rsp_code       = code_q;
  assign bus.rsp_len        = len_q;
  assign bus.rsp_ovf        = ovf_q;
  assign bus.busy           = busy_q;
`ifdef HJA_TIMEOUT_EN
  assign bus.rsp_err        = err_q;
`else
  assign bus.rsp_err        = 1'b0;
`endif
endmodule
